// File: rtl/mcu_spi_tx.sv
// SPI slave transmitter (mode 0, MSB first) that returns two status words to the MCU on MISO.
// NSS and SCK come from the MCU asynchronously and are synchronised into fpga_clock first.
module mcu_spi_tx #(
  parameter int WORD_BITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 fpga_clock,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] data_in0,
  input  logic [WORD_BITS-1:0] data_in1,
  input  logic                 data_valid,
  input  logic                 spi_nss,
  input  logic                 spi_clock_in,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_abort,
  output logic                 underrun
);

  localparam int FRAME_BITS = 2 * WORD_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  logic [SYNC_STAGES-1:0] nss_sync_q;
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic                   nss_prev_q;
  logic                   sck_prev_q;
  logic                   nss_s;
  logic                   sck_s;
  logic                   nss_fall_s;
  logic                   nss_rise_s;
  logic                   sck_rise_s;
  logic                   sck_fall_s;

  logic [1:0]            state_q,    state_d;
  logic [FRAME_BITS-1:0] hold_q,     hold_d;
  logic [FRAME_BITS-1:0] shift_q,    shift_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic                  fresh_q,    fresh_d;
  logic                  miso_q,     miso_d;
  logic                  oe_q,       oe_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;
  logic                  abort_q,    abort_d;
  logic                  underrun_q, underrun_d;
  logic [FRAME_BITS-1:0] dv_word_s;

  // Synchroniser chains reset low so that NSS already low at reset release is never seen as a fall.
  always_ff @(posedge fpga_clock or posedge reset) begin
    if (reset) begin
      nss_sync_q <= '0;
      sck_sync_q <= '0;
      nss_prev_q <= 1'b0;
      sck_prev_q <= 1'b0;
    end else begin
      nss_sync_q[0] <= spi_nss;
      sck_sync_q[0] <= spi_clock_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        nss_sync_q[i] <= nss_sync_q[i-1];
        sck_sync_q[i] <= sck_sync_q[i-1];
      end
      nss_prev_q <= nss_s;
      sck_prev_q <= sck_s;
    end
  end

  assign nss_s      = nss_sync_q[SYNC_STAGES-1];
  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign nss_fall_s = nss_prev_q & ~nss_s;
  assign nss_rise_s = ~nss_prev_q & nss_s;
  assign sck_rise_s = ~sck_prev_q & sck_s;
  assign sck_fall_s = sck_prev_q & ~sck_s;
  assign dv_word_s  = {data_in0, data_in1};

  // Frame sequencing: capture on NSS fall, count on SCK rise, shift on SCK fall, close on NSS rise.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    fresh_d    = fresh_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    underrun_d = 1'b0;

    if (data_valid) begin
      hold_d  = dv_word_s;
      fresh_d = 1'b1;
    end else begin
      hold_d  = hold_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (nss_fall_s) begin
          shift_d    = data_valid ? dv_word_s : hold_q;
          miso_d     = shift_d[FRAME_BITS-1];
          oe_d       = 1'b1;
          busy_d     = 1'b1;
          cnt_d      = '0;
          underrun_d = ~fresh_q & ~data_valid;
          fresh_d    = 1'b0;
          state_d    = ST_SHIFT;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_SHIFT, ST_FINISH: begin
        // NSS release takes priority over any SCK edge detected in the same cycle.
        if (nss_rise_s) begin
          oe_d    = 1'b0;
          miso_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = (state_q == ST_FINISH);
          abort_d = (state_q == ST_SHIFT);
          state_d = ST_IDLE;
        end else if (sck_rise_s) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
          if ((state_q == ST_SHIFT) && (cnt_q == CNT_LAST)) begin
            state_d = ST_FINISH;
            miso_d  = 1'b0;
          end else begin
            state_d = state_q;
          end
        end else if (sck_fall_s) begin
          shift_d = shift_q << 1;
          miso_d  = (state_q == ST_SHIFT) ? shift_q[FRAME_BITS-2] : 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        oe_d    = 1'b0;
        miso_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge fpga_clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      fresh_q    <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      fresh_q    <= fresh_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      underrun_q <= underrun_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign underrun    = underrun_q;

endmodule
